// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes the A/B phases, debounces the {a,b} level,
// and turns accepted Gray-code transitions into up/down steps on a wrapping
// position counter. Transitions where both phases change are flagged as
// errors and do not move the counter.
module quad_decoder #(
  parameter int CNT_W = 4,
  parameter int FILT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic             err_sticky
);

  localparam logic [3:0] FILT_V = 4'(FILT);

  logic [1:0] sync1;      // first synchronizer stage, {a,b}
  logic [1:0] sync2;      // second synchronizer stage, safe to use
  logic [1:0] warm;       // marks when sync2 holds a real sample rather than its reset value
  logic [1:0] cand;       // sync2 value seen on the previous edge
  logic [3:0] hold_cnt;   // edges the candidate has been stable, saturating at FILT
  logic [1:0] ref_ab;     // last accepted {a,b} level
  logic       ref_valid;  // ref_ab holds a real reference level

  logic [3:0] held;
  logic       accept;
  logic       evt;
  logic [1:0] delta;
  logic       fwd;
  logic       rev;
  logic       ill;

  // Map the Gray sequence 00,01,11,10 onto positions 0..3.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  // Two-flop synchronizer for the asynchronous phase inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, giving two real stages.
      sync1 <= {a, b};
      sync2 <= sync1;
    end
  end

  // Stability qualification and transition classification.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    held   = 4'd0;
    accept = 1'b0;
    evt    = 1'b0;
    delta  = 2'd0;
    fwd    = 1'b0;
    rev    = 1'b0;
    ill    = 1'b0;
    if (sync2 == cand) held = hold_cnt;
    accept = warm[1] && (held >= FILT_V) && (!ref_valid || (sync2 != ref_ab));
    evt    = accept && ref_valid;
    delta  = gray_pos(sync2) - gray_pos(ref_ab);
    fwd    = evt && (delta == 2'd1);
    rev    = evt && (delta == 2'd3);
    ill    = evt && (delta == 2'd2);
  end

  // Track how long the synchronized level has been unchanged; any change restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm     <= 2'b00;
      cand     <= 2'b00;
      hold_cnt <= 4'd0;
    end else begin
      warm <= {warm[0], 1'b1};
      cand <= sync2;
      if (!warm[1])
        hold_cnt <= 4'd0;
      else if (held >= FILT_V)
        hold_cnt <= FILT_V;
      else
        hold_cnt <= held + 4'd1;
    end
  end

  // Reference level: the first accepted level after reset only seeds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_ab    <= 2'b00;
      ref_valid <= 1'b0;
    end else if (accept) begin
      ref_ab    <= sync2;
      ref_valid <= 1'b1;
    end
  end

  // Registered outputs: counter, direction, pulses and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      dir        <= 1'b1;
      step       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      step <= fwd | rev;
      err  <= ill;
      if (fwd)
        dir <= 1'b1;
      else if (rev)
        dir <= 1'b0;
      // A clear wins over a step on the counter, but a fresh error wins over the clear.
      if (clr)
        count <= '0;
      else if (fwd)
        count <= count + 1'b1;
      else if (rev)
        count <= count - 1'b1;
      if (ill)
        err_sticky <= 1'b1;
      else if (clr)
        err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder at CNT_W=4, FILT=2 with hand-computed expectations.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       a;
  logic       b;
  logic       clr;
  logic [3:0] count;
  logic       dir;
  logic       step;
  logic       err;
  logic       err_sticky;

  int n_pass  = 0;
  int n_total = 0;
  int n_both  = 0;

  quad_decoder #(.CNT_W(4), .FILT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .clr        (clr),
    .count      (count),
    .dir        (dir),
    .step       (step),
    .err        (err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive a new {a,b} level just after a falling edge; the next rising edge is edge 0.
  task automatic set_ab(input logic [1:0] v);
    @(negedge clk);
    a = v[1];
    b = v[0];
  endtask

  // Run n rising edges, sampling 1 time unit after each, and count pulses seen.
  task automatic run(input int n, output int s, output int e);
    s = 0;
    e = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (step) s++;
      if (err) e++;
      if (step && err) n_both++;
    end
  endtask

  logic [1:0] fwd_seq [4];
  int s, e, s2, e2;

  initial begin
    fwd_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    rst = 1'b1;
    a   = 1'b0;
    b   = 1'b0;
    clr = 1'b0;
    run(3, s, e);
    check("rst_count", count, 0);
    check("rst_dir", dir, 1);
    check("rst_step", step, 0);
    check("rst_err", err, 0);
    check("rst_sticky", err_sticky, 0);

    // Release with ab=00, let the reference settle.
    @(negedge clk);
    rst = 1'b0;
    run(10, s, e);
    check("init00_steps", s, 0);
    check("init00_count", count, 0);

    // Forward sequence, each level held 5 cycles, update exactly at edge 4.
    for (int i = 0; i < 4; i++) begin
      set_ab(fwd_seq[i]);
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1;
        if (k == 0) check($sformatf("fwd%0d_e0_step", i), step, 0);
        if (k == 3) begin
          check($sformatf("fwd%0d_e3_step", i), step, 0);
          check($sformatf("fwd%0d_e3_count", i), count, i);
        end
        if (k == 4) begin
          check($sformatf("fwd%0d_e4_step", i), step, 1);
          check($sformatf("fwd%0d_e4_count", i), count, i + 1);
          check($sformatf("fwd%0d_e4_dir", i), dir, 1);
        end
      end
    end
    run(1, s, e);
    check("fwd_pulse_end", step, 0);
    check("fwd_count", count, 4);

    // Clear, then one reverse step from 0 wraps to 15.
    @(negedge clk);
    clr = 1'b1;
    run(1, s, e);
    check("clr_count", count, 0);
    @(negedge clk);
    clr = 1'b0;
    set_ab(2'b10);
    run(5, s, e);
    check("rev_steps", s, 1);
    check("rev_errs", e, 0);
    check("rev_count_wrap", count, 4'hf);
    check("rev_dir", dir, 0);
    set_ab(2'b00);
    run(5, s, e);
    check("wrap_up_count", count, 0);
    check("wrap_up_dir", dir, 1);

    // Illegal 00->11.
    set_ab(2'b11);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) check("ill_e3_err", err, 0);
    end
    check("ill_err", err, 1);
    check("ill_step", step, 0);
    check("ill_sticky", err_sticky, 1);
    check("ill_count", count, 0);
    check("ill_dir", dir, 1);
    run(1, s, e);
    check("ill_pulse_end", err, 0);
    check("ill_sticky_hold", err_sticky, 1);
    @(negedge clk);
    clr = 1'b1;
    run(1, s, e);
    check("clr_sticky", err_sticky, 0);
    check("clr_count2", count, 0);
    @(negedge clk);
    clr = 1'b0;

    // 11 is now the reference: 11->01 is a reverse step.
    set_ab(2'b01);
    run(6, s, e);
    check("ref_after_err_steps", s, 1);
    check("ref_after_err_errs", e, 0);
    check("ref_after_err_count", count, 4'hf);
    check("ref_after_err_dir", dir, 0);

    // Glitch a=1 for 2 cycles: rejected.
    set_ab(2'b11);
    @(posedge clk);
    @(posedge clk);
    set_ab(2'b01);
    run(8, s, e);
    check("glitch2_steps", s, 0);
    check("glitch2_errs", e, 0);
    check("glitch2_count", count, 4'hf);

    // Same glitch for 3 cycles: accepted as one forward step.
    set_ab(2'b11);
    run(3, s, e);
    set_ab(2'b01);
    run(2, s2, e2);
    check("glitch3_steps", s + s2, 1);
    check("glitch3_errs", e + e2, 0);
    check("glitch3_count", count, 0);
    check("glitch3_dir", dir, 1);
    run(6, s, e);
    check("glitch3_back_steps", s, 1);
    check("glitch3_back_count", count, 4'hf);

    // Reset released with ab=11: only seeds the reference.
    @(negedge clk);
    rst = 1'b1;
    a   = 1'b1;
    b   = 1'b1;
    run(2, s, e);
    check("rst11_count", count, 0);
    check("rst11_dir", dir, 1);
    @(negedge clk);
    rst = 1'b0;
    run(10, s, e);
    check("rst11_steps", s, 0);
    check("rst11_errs", e, 0);
    check("rst11_count_after", count, 0);
    set_ab(2'b10);
    run(5, s, e);
    check("rst11_fwd_steps", s, 1);
    check("rst11_fwd_count", count, 1);
    check("rst11_fwd_dir", dir, 1);

    // Reset during qualification of 10->00: pending step discarded.
    set_ab(2'b00);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midq_async_count", count, 0);
    check("midq_async_dir", dir, 1);
    check("midq_async_step", step, 0);
    run(3, s, e);
    check("midq_rst_steps", s, 0);
    @(negedge clk);
    rst = 1'b0;
    run(12, s, e);
    check("midq_steps", s, 0);
    check("midq_errs", e, 0);
    check("midq_count", count, 0);
    check("midq_sticky", err_sticky, 0);

    check("step_err_exclusive", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
